fpu_fp64_mul_seq: RTL
=====================

# fpu_fp64_mul_seq

Sequencer wrapped around the combinational FP64 multiplier (`FpuFp64_Mul`). It accepts operand pairs over a valid/ready request port and drives the multiplier's `enable`/`srca`/`srcb` inputs. It waits a fixed settle window, captures `dst`, repairs the cases the multiplier does not handle (NaN, Inf, zero/denormal, signed underflow), and presents the result with IEEE-style flags on a valid/ready response port toward the FPU writeback stage.

## Interface
- `MUL_LAT`, 2: cycles `mul_enable` is held before `mul_dst` is sampled; legal range 1..15.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request operands valid.
- `req_ready`  out  1  block can accept a request.
- `req_srca`  in  64  operand A, FP64.
- `req_srcb`  in  64  operand B, FP64.
- `req_tag`  in  4  opaque tag, returned unchanged on the response.
- `mul_enable`  out  1  drives the multiplier `enable` input.
- `mul_srca`  out  64  drives the multiplier `srca` input.
- `mul_srcb`  out  64  drives the multiplier `srcb` input.
- `mul_dst`  in  64  multiplier `dst` output.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_dst`  out  64  FP64 product.
- `rsp_tag`  out  4  tag of the request that produced this response.
- `rsp_flags`  out  4  response flags: [3] invalid, [2] overflow, [1] underflow, [0] special-bypass.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` the block latches the operands and tag, and computes `sgnc` = srca[63]^srcb[63].
  - If the operands are a special case (see Configuration), go to RESP. Otherwise go to ISSUE.
- ISSUE:
  - `mul_enable`=1 and `mul_srca`/`mul_srcb` = latched operands.
  - A 4-bit counter loads MUL_LAT-1 on entry and decrements each cycle.
  - Go to CAPTURE when the counter reaches 0.
- CAPTURE, one cycle:
  - `mul_enable`=1.
  - Register `mul_dst` into `rsp_dst`.
  - Overflow: `mul_dst`[62:52]==7FF → flag[2]=1.
  - Underflow: `mul_dst`==0 → flag[1]=1 and `rsp_dst` = {sgnc, 63'b0}, restoring the sign the multiplier drops.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_dst`, `rsp_tag` and `rsp_flags` are held stable.
  - On `rsp_ready`, go to IDLE.
- `mul_srca`/`mul_srcb` hold their last values outside ISSUE/CAPTURE. `mul_enable`=0 in IDLE and RESP.
- Operand classes: exponent 0 = zero (denormals are flushed, fraction ignored); exponent 7FF with fraction 0 = Inf; exponent 7FF with fraction ≠0 = NaN.

## Timing
- Reset (`reset_n`=0 at a rising edge) puts the FSM in IDLE and clears every output register:
  - `req_ready`=0 while `reset_n`=0, and 1 in the first cycle after release.
  - `mul_enable`=0, `mul_srca`=`mul_srcb`=0.
  - `rsp_valid`=0, `rsp_dst`=0, `rsp_tag`=0, `rsp_flags`=0.
- Reset in any state abandons the in-flight operation; no response is produced.
- Request accepted at edge N:
  - Normal path: `mul_enable` is high for cycles N+1 .. N+MUL_LAT+1 (MUL_LAT cycles of ISSUE plus one of CAPTURE); `rsp_valid` rises at N+MUL_LAT+2.
  - Bypass path: `rsp_valid` rises at N+1.
- Response handshake completes at the edge where `rsp_valid`&`rsp_ready`. `req_ready` returns high the following cycle. There is no same-cycle accept, so throughput is at most one operation per MUL_LAT+3 cycles.
- `rsp_ready` held low: the response is held indefinitely and `req_ready` stays 0.
- `req_valid` while `req_ready`=0 is ignored; the requester must hold it.

## Configuration
- `FPU_MUL_SPECIAL_EN` defined: operands are classified in IDLE and special cases bypass the multiplier (flag[0]=1):
  - NaN × any → 7FF8_0000_0000_0000, invalid.
  - Inf × zero → 7FF8_0000_0000_0000, invalid.
  - Inf × nonzero → {sgnc, 7FF, 52'b0}.
  - zero × finite → {sgnc, 63'b0}.
- `FPU_MUL_SPECIAL_EN` undefined:
  - Every request takes the ISSUE path.
  - flag[3] and flag[0] are tied to 0.
  - Only the overflow and underflow fixes in CAPTURE apply.

## Test plan
- MUL_LAT=2, A=3FF0_0000_0000_0000, B=4000_0000_0000_0000, `rsp_ready`=1 → `rsp_dst`=4000_0000_0000_0000, flags=0, `rsp_valid` at N+4, tag echoed.
- A=7FE0_0000_0000_0000, B=7FE0_0000_0000_0000 → `rsp_dst`=7FF0_0000_0000_0000, flags=0100.
- A=0010_0000_0000_0000, B=8010_0000_0000_0000 → `rsp_dst`=8000_0000_0000_0000, flags=0010.
- With the macro: A=7FF0_0000_0000_0000, B=0 → `rsp_dst`=7FF8_0000_0000_0000, flags=1001, `rsp_valid` at N+1, `mul_enable` never high. Without the macro, the same operands take the full latency and flags[3]=0.
- `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_dst`, `rsp_tag` and `rsp_flags` unchanged and `req_ready`=0; then `rsp_ready`=1 → `req_ready`=1 on the next cycle.
- `reset_n` pulsed low during ISSUE → next cycle all outputs 0; after release no response appears and the next request completes normally.

Source files
------------

// File: rtl/fpu_fp64_mul_seq.sv
// Request/response sequencer around the combinational FP64 multiplier: issue, settle, capture, fix up, respond.
// Optional build macro FPU_MUL_SPECIAL_EN: classify NaN/Inf/zero operands up front and bypass the multiplier.
module fpu_fp64_mul_seq #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_srca,
   input  logic [63:0] req_srcb,
   input  logic [3:0]  req_tag,
   output logic        mul_enable,
   output logic [63:0] mul_srca,
   output logic [63:0] mul_srcb,
   input  logic [63:0] mul_dst,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_dst,
   output logic [3:0]  rsp_tag,
   output logic [3:0]  rsp_flags
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid is held until that edge and the payload does not change while valid is high.

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        sgnc;
   logic        spc_hit;
   logic        spc_inv;
   logic [63:0] spc_dst;

`ifdef FPU_MUL_SPECIAL_EN
   logic req_sgn;
   logic a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;

   assign req_sgn = req_srca[63] ^ req_srcb[63];
   assign a_max   = (req_srca[62:52] == 11'h7FF);
   assign b_max   = (req_srcb[62:52] == 11'h7FF);
   assign a_zero  = (req_srca[62:52] == 11'h000);
   assign b_zero  = (req_srcb[62:52] == 11'h000);
   assign a_nan   = a_max & (|req_srca[51:0]);
   assign b_nan   = b_max & (|req_srcb[51:0]);
   assign a_inf   = a_max & ~(|req_srca[51:0]);
   assign b_inf   = b_max & ~(|req_srcb[51:0]);

   // Denormals count as zero because their fraction is flushed.
   always_comb begin
      spc_hit = 1'b1;
      spc_inv = 1'b0;
      spc_dst = 64'h0;
      if (a_nan | b_nan) begin
         spc_inv = 1'b1;
         spc_dst = 64'h7FF8_0000_0000_0000;
      end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
         spc_inv = 1'b1;
         spc_dst = 64'h7FF8_0000_0000_0000;
      end else if (a_inf | b_inf) begin
         spc_dst = {req_sgn, 11'h7FF, 52'h0};
      end else if (a_zero | b_zero) begin
         spc_dst = {req_sgn, 63'h0};
      end else begin
         spc_hit = 1'b0;
      end
   end
`else
   assign spc_hit = 1'b0;
   assign spc_inv = 1'b0;
   assign spc_dst = 64'h0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = spc_hit ? RESP : ISSUE;
         ISSUE:   if (cnt == 4'd0) state_nxt = CAPTURE;
         CAPTURE: state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = reset_n & (state == IDLE);
      mul_enable = (state == ISSUE) | (state == CAPTURE);
      rsp_valid  = (state == RESP);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt       <= 4'd0;
         sgnc      <= 1'b0;
         mul_srca  <= 64'h0;
         mul_srcb  <= 64'h0;
         rsp_dst   <= 64'h0;
         rsp_tag   <= 4'h0;
         rsp_flags <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rsp_tag <= req_tag;
                  sgnc    <= req_srca[63] ^ req_srcb[63];
                  if (spc_hit) begin
                     rsp_dst   <= spc_dst;
                     rsp_flags <= {spc_inv, 2'b00, 1'b1};
                  end else begin
                     mul_srca <= req_srca;
                     mul_srcb <= req_srcb;
                     cnt      <= 4'(MUL_LAT - 1);
                  end
               end
            end
            ISSUE: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
            end
            CAPTURE: begin
               // The multiplier returns an unsigned zero on underflow; put the product sign back.
               rsp_dst   <= (mul_dst == 64'h0) ? {sgnc, 63'h0} : mul_dst;
               rsp_flags <= {1'b0, (mul_dst[62:52] == 11'h7FF), (mul_dst == 64'h0), 1'b0};
            end
            default: ;
         endcase
      end
   end

endmodule
